// File: rtl/crc_mem_scheduler.sv
// Scheduler for a shared serial CRC engine: arbitrates encode (write) and check (read) requests.
// Optional macro CRC_READ_RETRY_EN: one automatic re-read after a failed CRC check.
module crc_mem_scheduler #(
    parameter int SHIFT_CYCLES = 12,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_req,
    input  logic       i_rd_req,
    input  logic       i_syndrome_zero,
    output logic       o_wr_gnt,
    output logic       o_rd_gnt,
    output logic       o_mem_rd_en,
    output logic       o_load_en,
    output logic       o_shift_en,
    output logic       o_mem_wr_en,
    output logic       o_busy,
    output logic       o_rd_valid,
    output logic       o_rd_err,
    output logic [2:0] o_dbg_state
);

    // Requests are levels: a requester holds its req until it sees the one-cycle gnt pulse.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_op_rd;
    logic             r_last_rd;
    logic             r_wr_gnt;
    logic             r_rd_gnt;
    logic             r_mem_rd_en;
    logic             r_load_en;
    logic             r_shift_en;
    logic             r_mem_wr_en;
    logic             r_busy;
    logic             r_rd_valid;
    logic             r_rd_err;
`ifdef CRC_READ_RETRY_EN
    logic             r_retry;
`endif

    // Strobe outputs are registered decodes of the state being left, so each lags its state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_op_rd     <= 1'b0;
            r_last_rd   <= 1'b1;
            r_wr_gnt    <= 1'b0;
            r_rd_gnt    <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_load_en   <= 1'b0;
            r_shift_en  <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
`ifdef CRC_READ_RETRY_EN
            r_retry     <= 1'b0;
`endif
        end else begin
            r_wr_gnt    <= 1'b0;
            r_rd_gnt    <= 1'b0;
            r_mem_rd_en <= (r_state == FETCH);
            r_load_en   <= (r_state == LOAD);
            r_shift_en  <= (r_state == SHIFT);
            r_mem_wr_en <= (r_state == WRITE);
            r_busy      <= (r_state != IDLE);
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef CRC_READ_RETRY_EN
                    r_retry <= 1'b0;
`endif
                    // On a tie the side not granted last wins.
                    if (i_wr_req && (!i_rd_req || r_last_rd)) begin
                        r_wr_gnt  <= 1'b1;
                        r_op_rd   <= 1'b0;
                        r_last_rd <= 1'b0;
                        r_state   <= LOAD;
                    end else if (i_rd_req) begin
                        r_rd_gnt  <= 1'b1;
                        r_op_rd   <= 1'b1;
                        r_last_rd <= 1'b1;
                        r_state   <= FETCH;
                    end
                end
                FETCH: r_state <= LOAD;
                LOAD: begin
                    r_count <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_count == LAST_CNT) begin
                        r_state <= r_op_rd ? CHECK : WRITE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                WRITE: r_state <= IDLE;
                CHECK: begin
`ifdef CRC_READ_RETRY_EN
                    if (!i_syndrome_zero && !r_retry) begin
                        r_retry <= 1'b1;
                        r_state <= FETCH;
                    end else begin
                        r_retry    <= 1'b0;
                        r_rd_valid <= 1'b1;
                        r_rd_err   <= ~i_syndrome_zero;
                        r_state    <= IDLE;
                    end
`else
                    r_rd_valid <= 1'b1;
                    r_rd_err   <= ~i_syndrome_zero;
                    r_state    <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_gnt    = r_wr_gnt;
    assign o_rd_gnt    = r_rd_gnt;
    assign o_mem_rd_en = r_mem_rd_en;
    assign o_load_en   = r_load_en;
    assign o_shift_en  = r_shift_en;
    assign o_mem_wr_en = r_mem_wr_en;
    assign o_busy      = r_busy;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_err    = r_rd_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crc_mem_scheduler.sv
// Bench for crc_mem_scheduler: latency-schedule model checked every cycle, plus directed timing pins.
module tb_crc_mem_scheduler;

    localparam int SC = 12;
`ifdef CRC_READ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    // Output vector bit positions
    localparam int WG = 8, RG = 7, MR = 6, LD = 5, SH = 4, MW = 3, BU = 2, RV = 1, RE = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       syn = 1'b1;
    logic       wr_gnt, rd_gnt, mem_rd_en, load_en, shift_en, mem_wr_en, busy, rd_valid, rd_err;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;

    crc_mem_scheduler #(.SHIFT_CYCLES(SC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_wr_req(wr_req), .i_rd_req(rd_req), .i_syndrome_zero(syn),
        .o_wr_gnt(wr_gnt), .o_rd_gnt(rd_gnt), .o_mem_rd_en(mem_rd_en),
        .o_load_en(load_en), .o_shift_en(shift_en), .o_mem_wr_en(mem_wr_en),
        .o_busy(busy), .o_rd_valid(rd_valid), .o_rd_err(rd_err),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: each operation is a fixed schedule of offsets from its grant cycle.
    bit         m_active, m_rd, m_retry, m_last_rd, m_idle;
    int         m_k;
    logic [8:0] exp_v = '0;
    logic [8:0] m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_k = 0; m_rd = 0; m_retry = 0; m_last_rd = 1; exp_v = '0;
        end else begin
            m_idle = !m_active || (!m_rd && m_k == SC + 2) || (m_rd && m_k == SC + 3);
            m_e = '0;
            m_e[BU] = !m_idle;
            if (m_idle) begin
                m_active = 0;
                m_retry = 0;
                if (wr_req && (!rd_req || m_last_rd)) begin
                    m_active = 1; m_k = 0; m_rd = 0; m_last_rd = 0; m_e[WG] = 1;
                end else if (rd_req) begin
                    m_active = 1; m_k = 0; m_rd = 1; m_last_rd = 1; m_e[RG] = 1;
                end
            end else begin
                m_k++;
                if (!m_rd) begin
                    if (m_k == 1) m_e[LD] = 1;
                    else if (m_k <= SC + 1) m_e[SH] = 1;
                    else m_e[MW] = 1;
                end else begin
                    if (m_k == 1) m_e[MR] = 1;
                    else if (m_k == 2) m_e[LD] = 1;
                    else if (m_k <= SC + 2) m_e[SH] = 1;
                    else if (RETRY && !syn && !m_retry) begin
                        m_retry = 1;
                        m_k = 0;
                    end else begin
                        m_e[RV] = 1;
                        m_e[RE] = !syn;
                    end
                end
            end
            exp_v = m_e;
        end
    end

    logic [8:0] act_v;
    always @(negedge clk) begin
        act_v = {wr_gnt, rd_gnt, mem_rd_en, load_en, shift_en, mem_wr_en, busy, rd_valid, rd_err};
        act_v[RE] = act_v[RE] & act_v[RV];
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL outputs: got %b expected %b at %0t", act_v, exp_v, $time);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit hold_wr, input bit hold_rd);
        rst = 1; wr_req = 0; rd_req = 0;
        repeat (3) tick();
        wr_req = hold_wr; rd_req = hold_rd;
        rst = 0;
    endtask

    task automatic wait_gnt(input bit want_rd, output bit found);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (want_rd ? rd_gnt : wr_gnt) found = 1;
        end
        check(want_rd ? "rd_gnt_seen" : "wr_gnt_seen", found, 1);
    endtask

    task automatic measure_write(input string tag);
        bit found;
        int first_ld, first_sh, n_sh, wr_t, busy_low;
        first_ld = -1; first_sh = -1; n_sh = 0; wr_t = -1; busy_low = -1;
        wr_req = 1;
        wait_gnt(0, found);
        wr_req = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (load_en && first_ld < 0) first_ld = t;
            if (shift_en) begin n_sh++; if (first_sh < 0) first_sh = t; end
            if (mem_wr_en && wr_t < 0) wr_t = t;
            if (!busy && t >= 2 && busy_low < 0) busy_low = t;
        end
        check({tag, "_load_t"}, first_ld, 1);
        check({tag, "_shift_t"}, first_sh, 2);
        check({tag, "_shift_n"}, n_sh, SC);
        check({tag, "_wr_t"}, wr_t, 14);
        check({tag, "_idle_t"}, busy_low, 15);
    endtask

    task automatic measure_read(input string tag, input logic s1, input logic s2,
                                input int exp_nrd, input int exp_valid_t, input int exp_err);
        bit found;
        int n_rd, rd2_t, first_rd, first_sh, valid_t, err_v;
        n_rd = 0; rd2_t = -1; first_rd = -1; first_sh = -1; valid_t = -1; err_v = -1;
        syn = s1;
        rd_req = 1;
        wait_gnt(1, found);
        rd_req = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (mem_rd_en) begin
                n_rd++;
                if (n_rd == 1) first_rd = t;
                if (n_rd == 2) begin rd2_t = t; syn = s2; end
            end
            if (shift_en && first_sh < 0) first_sh = t;
            if (rd_valid && valid_t < 0) begin valid_t = t; err_v = rd_err; end
        end
        check({tag, "_mem_rd_t"}, first_rd, 1);
        check({tag, "_shift_t"}, first_sh, 3);
        check({tag, "_mem_rd_n"}, n_rd, exp_nrd);
        if (exp_nrd == 2) check({tag, "_mem_rd2_t"}, rd2_t, 16);
        check({tag, "_valid_t"}, valid_t, exp_valid_t);
        check({tag, "_err"}, err_v, exp_err);
    endtask

    initial begin
        bit found;
        int g_t[3];
        bit g_rd[3];
        int ng, nwr;

        #1 rst = 1;
        do_reset(0, 0);
        check("reset_busy", busy, 0);

        measure_write("wr_alone");
        measure_read("rd_ok", 1'b1, 1'b1, 1, 15, 0);
        if (RETRY) measure_read("rd_bad_retry_ok", 1'b0, 1'b1, 2, 30, 0);
        else       measure_read("rd_bad", 1'b0, 1'b1, 1, 15, 1);
        if (RETRY) measure_read("rd_bad_twice", 1'b0, 1'b0, 2, 30, 1);
        syn = 1;

        // Both requests held from reset: write first, then strict alternation.
        do_reset(1, 1);
        ng = 0;
        for (int t = 0; t < 60 && ng < 3; t++) begin
            tick();
            if (wr_gnt || rd_gnt) begin g_t[ng] = t; g_rd[ng] = rd_gnt; ng++; end
        end
        wr_req = 0; rd_req = 0;
        check("tie_grant_n", ng, 3);
        if (ng == 3) begin
            check("tie_g0_rd", g_rd[0], 0);
            check("tie_g1_rd", g_rd[1], 1);
            check("tie_g2_rd", g_rd[2], 0);
            check("tie_gap_w_r", g_t[1] - g_t[0], 15);
            check("tie_gap_r_w", g_t[2] - g_t[1], 16);
        end
        repeat (20) tick();

        // Abort a write in the middle of SHIFT.
        do_reset(0, 0);
        wr_req = 1;
        wait_gnt(0, found);
        wr_req = 0;
        repeat (6) tick();
        check("abort_in_shift", shift_en, 1);
        rst = 1;
        tick();
        check("abort_outputs", {wr_gnt, rd_gnt, mem_rd_en, load_en, shift_en, mem_wr_en, busy, rd_valid, rd_err}, 0);
        tick();
        rst = 0;
        nwr = 0;
        for (int t = 0; t < 25; t++) begin
            tick();
            if (mem_wr_en || rd_valid) nwr++;
        end
        check("abort_no_wr", nwr, 0);
        measure_write("wr_after_abort");

        // Random traffic: requesters hold until granted, sometimes give up; occasional reset.
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (wr_gnt) wr_req = 0;
            else if (wr_req && $urandom_range(0, 19) == 0) wr_req = 0;
            else if (!wr_req && $urandom_range(0, 3) == 0) wr_req = 1;
            if (rd_gnt) rd_req = 0;
            else if (rd_req && $urandom_range(0, 19) == 0) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 3) == 0) rd_req = 1;
            syn = ($urandom_range(0, 2) != 0);
            if (rst) rst = 0;
            else if ($urandom_range(0, 499) == 0) rst = 1;
        end
        rst = 0; wr_req = 0; rd_req = 0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
